exe_operand_ctrl: RTL

EXE_OPERAND_CTRL -- requirements
Module: exe_operand_ctrl

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fwd_unit.sv | 59 +++++
 rtl/exe_operand_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the EXE operand control slice.
// Holds forwarding-select codes, hazard FSM states and the match helper.
package mips_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EXE  = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_LOAD = 2'b11;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // r0 is hardwired to zero, so a write to it is never a real producer.
  function automatic logic src_match(
    input logic       used,
    input logic [4:0] src,
    input logic [4:0] dst,
    input logic       wreg
  );
    return used & wreg & (src == dst) & (src != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational hazard detection and operand forwarding selection.
// Ports: ID sources/uses in, E/M destinations in; fwda_o/fwdb_o/stall_o out.
// Macro EXE_OPERAND_FWD_EN: defined -> forwarding; undefined -> stall only.
module fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] drs_i,
  input  logic [4:0] drt_i,
  input  logic       dusers_i,
  input  logic       dusert_i,
  input  logic [4:0] ern_i,
  input  logic       ewreg_i,
  input  logic       em2reg_i,
  input  logic [4:0] mrn_i,
  input  logic       mwreg_i,
  input  logic       mm2reg_i,
  output logic [1:0] fwda_o,
  output logic [1:0] fwdb_o,
  output logic       stall_o
);

  logic ea, eb, ma, mb;

  assign ea = src_match(dusers_i, drs_i, ern_i, ewreg_i);
  assign eb = src_match(dusert_i, drt_i, ern_i, ewreg_i);
  assign ma = src_match(dusers_i, drs_i, mrn_i, mwreg_i);
  assign mb = src_match(dusert_i, drt_i, mrn_i, mwreg_i);

`ifdef EXE_OPERAND_FWD_EN
  // The younger EXE producer wins over MEM.
  function automatic logic [1:0] sel(
    input logic e,
    input logic m
  );
    logic [1:0] s;
    s = FWD_REG;
    unique case (1'b1)
      (e & ~em2reg_i): s = FWD_EXE;
      (e &  em2reg_i): s = FWD_REG;
      (m & ~mm2reg_i): s = FWD_MEM;
      (m &  mm2reg_i): s = FWD_LOAD;
      default:         s = FWD_REG;
    endcase
    return s;
  endfunction

  assign fwda_o  = sel(ea, ma);
  assign fwdb_o  = sel(eb, mb);
  // Load data is not ready until MEM: one bubble.
  assign stall_o = (ea | eb) & em2reg_i;
`else
  logic unused_m2reg;
  assign unused_m2reg = em2reg_i ^ mm2reg_i;
  assign fwda_o  = FWD_REG;
  assign fwdb_o  = FWD_REG;
  assign stall_o = ea | eb | ma | mb;
`endif

endmodule

// File: rtl/exe_operand_ctrl.sv
// ID->EXE->MEM control tracking, hazard stall FSM and stall counter.
// Ports: ID fields in; E/M regs, fwda/fwdb, wpcir, stall_cnt out.
// Macro EXE_OPERAND_FWD_EN enables forwarding (see fwd_unit).
module exe_operand_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        dusers,
  input  logic        dusert,
  input  logic [4:0]  drn,
  input  logic        dwreg,
  input  logic        dm2reg,
  input  logic        daluimm,
  output logic [4:0]  ern,
  output logic [4:0]  mrn,
  output logic        ewreg,
  output logic        em2reg,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        ealuimm,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        wpcir,
  output logic [15:0] stall_cnt
);

  logic [4:0]  ern_q, mrn_q;
  logic        ewreg_q, em2reg_q, ealuimm_q;
  logic        mwreg_q, mm2reg_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  state_e      state_q, state_d;
  logic        stall;

  fwd_unit u_fwd (
    .drs_i    (drs),
    .drt_i    (drt),
    .dusers_i (dusers),
    .dusert_i (dusert),
    .ern_i    (ern_q),
    .ewreg_i  (ewreg_q),
    .em2reg_i (em2reg_q),
    .mrn_i    (mrn_q),
    .mwreg_i  (mwreg_q),
    .mm2reg_i (mm2reg_q),
    .fwda_o   (fwda),
    .fwdb_o   (fwdb),
    .stall_o  (stall)
  );

  always_comb begin
    state_d     = state_q;
    wpcir       = ~stall;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN:     if (stall)  state_d = STALL;
      STALL:   if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (stall && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      ern_q       <= '0;
      ewreg_q     <= 1'b0;
      em2reg_q    <= 1'b0;
      ealuimm_q   <= 1'b0;
      mrn_q       <= '0;
      mwreg_q     <= 1'b0;
      mm2reg_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      mrn_q       <= ern_q;
      mwreg_q     <= ewreg_q;
      mm2reg_q    <= em2reg_q;
      // A held ID instruction must not issue twice: insert a bubble.
      if (stall) begin
        ern_q     <= '0;
        ewreg_q   <= 1'b0;
        em2reg_q  <= 1'b0;
        ealuimm_q <= 1'b0;
      end else begin
        ern_q     <= drn;
        ewreg_q   <= dwreg;
        em2reg_q  <= dm2reg;
        ealuimm_q <= daluimm;
      end
    end
  end

  assign ern       = ern_q;
  assign mrn       = mrn_q;
  assign ewreg     = ewreg_q;
  assign em2reg    = em2reg_q;
  assign mwreg     = mwreg_q;
  assign mm2reg    = mm2reg_q;
  assign ealuimm   = ealuimm_q;
  assign stall_cnt = stall_cnt_q;

endmodule
